// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register map,
// CTRL bit layout, interrupt source numbering and the priority helper.
package dmem_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

    localparam logic [7:0] OFF_CNT  = 8'h00;
    localparam logic [7:0] OFF_CMP  = 8'h04;
    localparam logic [7:0] OFF_CTRL = 8'h08;
    localparam logic [7:0] OFF_PEND = 8'h0C;
    localparam logic [7:0] OFF_MASK = 8'h10;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_AUTOCLR_BIT = 1;

    localparam int IRQ_SRC_TIMER = 0;
    localparam int NUM_IRQ       = 8;

    // Field order puts EN at bit 0 and AUTOCLR at bit 1 of the CTRL register.
    typedef struct packed {
        logic autoclr;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        REGION_RAM     = 2'd0,
        REGION_RAM_OOR = 2'd1,
        REGION_MMIO    = 2'd2
    } region_e;

    // Lowest set index wins; an all-zero vector yields 0.
    function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmem_responder_irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one lane per bit.
// The pulse is combinational from the synchronized and delayed stages.
module irq_sync_edge #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window with a timer/compare unit
// and an 8-source pending/mask interrupt unit driving the core's IRQ inputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [15:0] MMIO_HI   = MMIO_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wd,
    output logic [31:0] dmem_rd,
    input  logic [7:0]  ext_irq,
    output logic        irq_valid,
    output logic [2:0]  irq_code
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] mem [RAM_WORDS];

    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic [7:0]    mmio_off;
    region_e       region;

    logic wr_cnt, wr_cmp, wr_ctrl, wr_pend, wr_mask, wr_ram;

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  mask_q, mask_d;
    logic        irq_valid_q;
    logic [2:0]  irq_code_q;

    logic        timer_match;
    logic [6:0]  ext_rise;
    logic [7:0]  irq_set;
    logic [7:0]  active;

    logic unused_bits;
    assign unused_bits = ^{ext_irq[0], dmem_addr[1:0]};

    assign word_idx = dmem_addr[31:2];
    assign ram_idx  = word_idx[AW-1:0];
    assign mmio_off = {dmem_addr[7:2], 2'b00};

    always_comb begin
        region = REGION_RAM_OOR;
        if (dmem_addr[31:16] == MMIO_HI) begin
            region = REGION_MMIO;
        end else if (word_idx < 30'(RAM_WORDS)) begin
            region = REGION_RAM;
        end
    end

    always_comb begin
        wr_cnt  = 1'b0;
        wr_cmp  = 1'b0;
        wr_ctrl = 1'b0;
        wr_pend = 1'b0;
        wr_mask = 1'b0;
        wr_ram  = dmem_we && (region == REGION_RAM);
        if (dmem_we && (region == REGION_MMIO)) begin
            case (mmio_off)
                OFF_CNT:  wr_cnt  = 1'b1;
                OFF_CMP:  wr_cmp  = 1'b1;
                OFF_CTRL: wr_ctrl = 1'b1;
                OFF_PEND: wr_pend = 1'b1;
                OFF_MASK: wr_mask = 1'b1;
                default:  ;
            endcase
        end
    end

    // Zero-latency read path; the single-cycle core samples it in the same cycle.
    always_comb begin
        dmem_rd = 32'd0;
        if (region == REGION_MMIO) begin
            case (mmio_off)
                OFF_CNT:  dmem_rd = cnt_q;
                OFF_CMP:  dmem_rd = cmp_q;
                OFF_CTRL: dmem_rd = {30'd0, ctrl_q};
                OFF_PEND: dmem_rd = {24'd0, pend_q};
                OFF_MASK: dmem_rd = {24'd0, mask_q};
                default:  dmem_rd = 32'd0;
            endcase
        end else if (region == REGION_RAM) begin
            dmem_rd = mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= dmem_wd;
        end
    end

    assign timer_match = ctrl_q.en && (cnt_q == cmp_q);

    // A CPU write to CNT overrides the increment in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = dmem_wd;
        end else if (ctrl_q.en) begin
            cnt_d = (timer_match && ctrl_q.autoclr) ? 32'd0 : cnt_q + 32'd1;
        end
    end

    always_comb begin
        cmp_d  = wr_cmp  ? dmem_wd : cmp_q;
        ctrl_d = wr_ctrl ? ctrl_t'(dmem_wd[CTRL_AUTOCLR_BIT:CTRL_EN_BIT]) : ctrl_q;
        mask_d = wr_mask ? dmem_wd[7:0] : mask_q;
    end

    irq_sync_edge #(
        .WIDTH(7)
    ) u_ext_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(ext_irq[7:1]),
        .rise_o (ext_rise)
    );

    assign irq_set = {ext_rise, timer_match};

    // Set pulses are OR'd in after the W1C so a same-cycle set wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_q & ~dmem_wd[7:0];
        end
        pend_d = pend_d | irq_set;
    end

    assign active = pend_q & mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 32'd0;
            cmp_q       <= 32'd0;
            ctrl_q      <= '0;
            pend_q      <= 8'd0;
            mask_q      <= 8'd0;
            irq_valid_q <= 1'b0;
            irq_code_q  <= 3'd0;
        end else begin
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
            ctrl_q      <= ctrl_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            irq_valid_q <= |active;
            irq_code_q  <= lowest_set(active);
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_code  = irq_code_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed timer/IRQ/reset scenarios plus
// randomized RAM traffic and external-interrupt patterns against a simple model.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam logic [31:0] ADDR_CNT  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_CMP  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CTRL = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_PEND = 32'hFFFF_000C;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;
    logic [7:0]  ext_irq;
    logic        irq_valid;
    logic [2:0]  irq_code;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] ramModel [int];
    logic [7:0]  modelPend;
    logic [7:0]  modelMask;

    dmem_responder #(
        .RAM_WORDS(256),
        .MMIO_HI  (16'hFFFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dmem_we  (dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wd  (dmem_wd),
        .dmem_rd  (dmem_rd),
        .ext_irq  (ext_irq),
        .irq_valid(irq_valid),
        .irq_code (irq_code)
    );

    always #10 clk = ~clk;

    function automatic logic [2:0] expCode(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        dmem_we   = we;
        dmem_addr = addr;
        dmem_wd   = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, addr, wd);
        tick(1);
        applyStimulus(1'b0, addr, 32'd0);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(1'b0, addr, 32'd0);
        #1;
        checkOutput(tag, dmem_rd, exp);
    endtask

    task automatic irqCheck(input string tag, input logic [7:0] pend, input logic [7:0] mask);
        checkOutput({tag, "_valid"}, {31'd0, irq_valid}, {31'd0, |(pend & mask)});
        checkOutput({tag, "_code"}, {29'd0, irq_code}, {29'd0, expCode(pend & mask)});
    endtask

    initial begin
        int          idxQ[$];
        int          idx;
        logic [31:0] data;
        logic [6:0]  pat;

        rst_n = 1'b0;
        ext_irq = 8'd0;
        applyStimulus(1'b0, 32'd0, 32'd0);
        modelPend = 8'd0;
        modelMask = 8'd0;
        #25 rst_n = 1'b1;
        tick(1);

        irqCheck("reset", modelPend, modelMask);
        readCheck("reset_cnt", ADDR_CNT, 32'd0);
        readCheck("reset_ctrl", ADDR_CTRL, 32'd0);
        readCheck("reset_pend", ADDR_PEND, 32'd0);
        readCheck("reset_mask", ADDR_MASK, 32'd0);

        // RAM directed
        busWrite(32'h0000_0000, 32'h0000_0000);
        busWrite(32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_word", 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
        busWrite(32'h0000_0400, 32'h1234_5678);
        readCheck("ram_oor_read", 32'h0000_0400, 32'd0);
        readCheck("ram_oor_nowrap", 32'h0000_0000, 32'd0);
        readCheck("mmio_unmapped", 32'hFFFF_0020, 32'd0);

        // RAM random traffic, in and out of range
        for (int k = 0; k < 16; k++) begin
            idx  = int'($urandom_range(0, 299));
            data = $urandom;
            busWrite(32'(idx) << 2, data);
            if (idx < 256) ramModel[idx] = data;
            idxQ.push_back(idx);
        end
        foreach (idxQ[k]) begin
            idx = idxQ[k];
            readCheck("ram_rand", (32'(idx) << 2) | 32'($urandom_range(0, 3)),
                      (idx < 256) ? ramModel[idx] : 32'd0);
        end

        // Timer with autoclear
        busWrite(ADDR_CMP, 32'd5);
        busWrite(ADDR_MASK, 32'h01);
        modelMask = 8'h01;
        busWrite(ADDR_CTRL, 32'h3);
        for (int k = 0; k <= 5; k++) begin
            readCheck("timer_cnt", ADDR_CNT, 32'(k));
            readCheck("timer_pend_pre", ADDR_PEND, 32'd0);
            tick(1);
        end
        modelPend = 8'h01;
        readCheck("timer_autoclr", ADDR_CNT, 32'd0);
        readCheck("timer_pend", ADDR_PEND, 32'h01);
        irqCheck("timer_irq_pre", 8'h00, modelMask);
        tick(1);
        irqCheck("timer_irq", modelPend, modelMask);
        busWrite(ADDR_CTRL, 32'h0);
        readCheck("timer_stop_cnt", ADDR_CNT, 32'd2);
        busWrite(ADDR_PEND, 32'h01);
        readCheck("timer_w1c_pend", ADDR_PEND, 32'd0);
        irqCheck("timer_w1c_same", modelPend, modelMask);
        modelPend = 8'h00;
        tick(1);
        irqCheck("timer_w1c_drop", modelPend, modelMask);

        // External edge on source 3, line held high
        busWrite(ADDR_MASK, 32'h08);
        modelMask = 8'h08;
        busWrite(ADDR_PEND, 32'hFF);
        ext_irq = 8'h08;
        tick(2);
        readCheck("ext_pend_e1", ADDR_PEND, 32'd0);
        tick(1);
        modelPend = 8'h08;
        readCheck("ext_pend_e2", ADDR_PEND, 32'h08);
        irqCheck("ext_irq_e2", 8'h00, modelMask);
        tick(1);
        irqCheck("ext_irq_e3", modelPend, modelMask);
        busWrite(ADDR_PEND, 32'h08);
        modelPend = 8'h00;
        tick(3);
        readCheck("ext_held_noreset", ADDR_PEND, 32'd0);
        irqCheck("ext_cleared", modelPend, modelMask);

        // Priority between sources 3 and 5
        busWrite(ADDR_MASK, 32'hFF);
        modelMask = 8'hFF;
        ext_irq = 8'h00;
        tick(3);
        ext_irq = 8'h28;
        tick(3);
        modelPend = 8'h28;
        readCheck("prio_pend", ADDR_PEND, 32'h28);
        tick(1);
        irqCheck("prio_both", modelPend, modelMask);
        busWrite(ADDR_PEND, 32'h08);
        modelPend = 8'h20;
        tick(1);
        irqCheck("prio_five", modelPend, modelMask);
        busWrite(ADDR_PEND, 32'h20);
        modelPend = 8'h00;
        tick(1);
        irqCheck("prio_none", modelPend, modelMask);
        ext_irq = 8'h00;
        tick(3);

        // Random external patterns under random masks
        for (int k = 0; k < 6; k++) begin
            pat = 7'($urandom_range(1, 127));
            modelMask = 8'($urandom_range(0, 255));
            busWrite(ADDR_MASK, {24'd0, modelMask});
            busWrite(ADDR_PEND, 32'hFF);
            ext_irq = {pat, 1'b0};
            tick(3);
            modelPend = {pat, 1'b0};
            readCheck("rand_pend", ADDR_PEND, {24'd0, modelPend});
            tick(1);
            irqCheck("rand_irq", modelPend, modelMask);
            ext_irq = 8'h00;
            tick(3);
            busWrite(ADDR_PEND, 32'hFF);
        end

        // Same-cycle timer match and W1C, then CNT write priority
        busWrite(ADDR_CMP, 32'd3);
        busWrite(ADDR_CNT, 32'd0);
        busWrite(ADDR_CTRL, 32'h1);
        readCheck("sim_cnt0", ADDR_CNT, 32'd0);
        tick(3);
        readCheck("sim_cnt3", ADDR_CNT, 32'd3);
        busWrite(ADDR_PEND, 32'h01);
        readCheck("sim_setwins", ADDR_PEND, 32'h01);
        readCheck("sim_noclr", ADDR_CNT, 32'd4);
        busWrite(ADDR_CNT, 32'd100);
        readCheck("cnt_write", ADDR_CNT, 32'd100);
        tick(1);
        readCheck("cnt_write_inc", ADDR_CNT, 32'd101);

        // Asynchronous reset mid-count with an interrupt asserted
        busWrite(ADDR_CTRL, 32'h0);
        busWrite(ADDR_PEND, 32'hFF);
        busWrite(ADDR_MASK, 32'h01);
        busWrite(ADDR_CMP, 32'd2);
        busWrite(ADDR_CNT, 32'd0);
        busWrite(ADDR_CTRL, 32'h3);
        tick(4);
        irqCheck("rst_pre", 8'h01, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        modelPend = 8'h00;
        modelMask = 8'h00;
        irqCheck("rst_async", modelPend, modelMask);
        readCheck("rst_cnt", ADDR_CNT, 32'd0);
        readCheck("rst_ctrl", ADDR_CTRL, 32'd0);
        readCheck("rst_pend", ADDR_PEND, 32'd0);
        readCheck("rst_mask", ADDR_MASK, 32'd0);
        #2 rst_n = 1'b1;
        tick(3);
        readCheck("rst_timer_stopped", ADDR_CNT, 32'd0);
        irqCheck("rst_after", modelPend, modelMask);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle core. It serves the core's `dmem_*` port with a word-addressed RAM and a memory-mapped peripheral window. The window holds a 32-bit timer/compare unit and an 8-source interrupt pending/mask unit. The block drives the core's 3-bit IRQ code, qualified by a valid flag, so it is the other end of both the data bus and the interrupt input.

## Interface
- `RAM_WORDS`, default 256: RAM depth in 32-bit words, a power of 2.
- `MMIO_HI`, default 16'hFFFF: the value of `dmem_addr[31:16]` that selects the MMIO window.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `dmem_we`, input, 1: write strobe from the core.
- `dmem_addr`, input, 32: byte address. Bits [1:0] are ignored.
- `dmem_wd`, input, 32: write data.
- `dmem_rd`, output, 32: read data, combinational from `dmem_addr`.
- `ext_irq`, input, 8: asynchronous external interrupt lines. Bit 0 is unused, because the timer owns source 0.
- `irq_valid`, output, 1: registered. High when any unmasked interrupt is pending.
- `irq_code`, output, 3: registered. Index of the highest-priority unmasked pending source.

## Operation
- **Decode.**
  - MMIO is selected when `dmem_addr[31:16]==MMIO_HI`.
  - Otherwise the access is RAM at word index `dmem_addr[31:2]`.
  - A RAM index ≥ `RAM_WORDS` reads 0, and writes to it are ignored.
- **RAM.**
  - Read is asynchronous; write is synchronous.
  - RAM contents are not reset.
- **MMIO registers**, at offset `dmem_addr[7:0]`. All reset to 0. Unmapped offsets read 0 and ignore writes.
  - 0x00 `CNT`, RW: timer count. A CPU write has priority over the increment in the same cycle.
  - 0x04 `CMP`, RW: compare value.
  - 0x08 `CTRL`, RW, bits [1:0]:
    - bit 0 `EN`: the count increments each cycle when set.
    - bit 1 `AUTOCLR`: on a match, the next count is 0 instead of count+1.
  - 0x0C `PEND`, RW1C, bits [7:0]: writing 1 to a bit clears it.
  - 0x10 `MASK`, RW, bits [7:0].
- **Timer.**
  - Match is combinational: `EN && CNT==CMP`.
  - A match produces a one-cycle set pulse for source 0. It is not level-held, because the count moves on.
  - The count wraps from 0xFFFFFFFF to 0 with no flag.
- **Interrupt sources.**
  - Source 0 is the timer match.
  - Sources 7:1 are the `ext_irq[7:1]` lines. Each passes through a 2-flop synchronizer and then a rising-edge detector.
- **Pending.**
  - A set pulse sets its `PEND` bit.
  - A set and a W1C on the same bit in the same cycle leave the bit set (set wins).
- **Output.**
  - `irq_valid <= |(PEND & MASK)`.
  - `irq_code <=` lowest set index of `PEND & MASK`. Index 0 is highest priority.
  - When nothing is pending, `irq_code` holds 0.
  - Interrupts are not acknowledged automatically; software clears them through `PEND`.

## Timing
- **Reset.**
  - Assertion is asynchronous: all MMIO registers, synchronizer and edge flops, `irq_valid` and `irq_code` go to 0 immediately.
  - `dmem_rd` reflects the reset register values combinationally.
- **Reads.** Zero latency: `dmem_rd` is valid in the same cycle the address is presented, as the single-cycle core requires.
- **Writes.** Take effect at the rising edge ending the cycle in which `dmem_we` is high. The new value is readable in the next cycle.
- **Timer to output.**
  - Match in cycle N: `PEND[0]` is set at edge N+1.
  - `irq_valid`/`irq_code` update at edge N+2.
- **External line to output.**
  - `ext_irq[i]` rises before edge E: sync stage 2 at E+1, edge detected and `PEND[i]` set at E+2.
  - `irq_valid`/`irq_code` update at E+3.
- **W1C to output.** The clear takes effect at the write edge; `irq_valid` drops one edge later if no other unmasked bit remains pending.
- **Mask write.** Affects the outputs one edge after the write edge.
- **Reset mid-operation.** A pending interrupt or running timer is discarded completely. After release, the first increment happens only once `EN` is written again.

## Structure
- **Shared package** `dmem_pkg`:
  - MMIO offset constants (`OFF_CNT`, `OFF_CMP`, `OFF_CTRL`, `OFF_PEND`, `OFF_MASK`).
  - `CTRL` bit positions.
  - `IRQ_SRC_TIMER=0`.
  - `MMIO_HI` default.
- **Sub-module** `irq_sync_edge`: parameterized width. Contains the 2-flop synchronizer plus the rising-edge pulse, reset to 0 by `rst_n`. Instantiated once, 7 bits wide, for `ext_irq[7:1]`.
- **Top level** holds the RAM array, decode, timer, pending/mask registers and the priority encoder.

## Test plan
- **RAM.** Write 0xDEADBEEF to 0x00000010, then read 0x00000010 (and 0x00000013) → 0xDEADBEEF. Write to 0x00000400 (index 256) → ignored; reading 0x00000400 → 0.
- **Timer.**
  - Setup: `CMP`=5, `MASK`=0x01, `CTRL`=0x3.
  - `CNT` counts 0..5, then reads 0 in the cycle after the match.
  - `PEND`=0x01 one edge after the match; `irq_valid`=1 and `irq_code`=0 one edge later.
  - W1C 0x01 → `irq_valid`=0 one edge after the write.
- **External edge.** With `MASK`=0x08, raise `ext_irq[3]` and hold it high:
  - `PEND`=0x08 at E+2; `irq_valid`=1 and `irq_code`=3 at E+3.
  - Keeping the line high does not re-set the bit after a W1C.
- **Priority.** Pend sources 3 and 5 with `MASK`=0xFF → `irq_code`=3. Clear bit 3 → `irq_code`=5. Clear bit 5 → `irq_valid`=0, `irq_code`=0.
- **Simultaneous events.**
  - Timer match in the same cycle as a W1C of `PEND[0]` → `PEND[0]` remains 1.
  - CPU write `CNT`=100 while the timer is enabled → reads 100, then 101.
- **Reset.** Assert `rst_n`=0 asynchronously mid-count with `irq_valid`=1 → `irq_valid`, `irq_code`, `CNT`, `CTRL`, `PEND` and `MASK` read 0 before the next clock edge. After release the timer stays stopped.
